photobooth_ctrl: RTL and testbench

Parametrised photobooth sequencer on the 65 MHz video clock. It replaces the ad-hoc state register in the top level. It turns debounced button presses into:
- a countdown,
- a multi-shot frame-buffer freeze,
- filter selection,
- processing and transmit handshakes.

It drives the frame-buffer write gate, the filter mux select and the overlay/status signals consumed by the start-screen and VGA mux logic.

---
 rtl/photobooth_pkg.sv | 21 ++
 rtl/photobooth_ctrl_sec_tick.sv | 33 +++
 rtl/photobooth_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_photobooth_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/photobooth_pkg.sv
// photobooth_pkg: state encoding, filter ids and clock default
// shared by the photobooth sequencer and its tick generator.
package photobooth_pkg;

  localparam int PB_CLK_HZ = 65_000_000;

  typedef enum logic [2:0] {
    PB_IDLE      = 3'd0,
    PB_COUNTDOWN = 3'd1,
    PB_CAPTURE   = 3'd2,
    PB_CHOOSE    = 3'd3,
    PB_PROCESS   = 3'd4,
    PB_SEND      = 3'd5
  } pb_state_t;

  localparam logic [3:0] FILT_NONE   = 4'd0;
  localparam logic [3:0] FILT_GRAY   = 4'd1;
  localparam logic [3:0] FILT_INVERT = 4'd2;
  localparam logic [3:0] FILT_EDGE   = 4'd3;

endpackage

// File: rtl/photobooth_ctrl_sec_tick.sv
// sec_tick: one-cycle strobe every CLK_HZ cycles, with a
// synchronous restart that zeroes the phase counter.
module sec_tick
  import photobooth_pkg::*;
#(
  parameter int CLK_HZ = PB_CLK_HZ
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic restart_in,
  output logic tick_out
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // advance phase, wrap at the last count or on restart
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (restart_in || cnt_q == LAST) cnt_d = '0;
  end

  // phase counter register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign tick_out = (cnt_q == LAST) && !restart_in;

endmodule

// File: rtl/photobooth_ctrl.sv
// photobooth_ctrl: button-driven countdown / capture / filter /
// handshake sequencer. Optional CHOOSE idle timeout: PHOTOBOOTH_TIMEOUT_EN.
module photobooth_ctrl
  import photobooth_pkg::*;
#(
  parameter int CLK_HZ      = PB_CLK_HZ,
  parameter int COUNT_SEC   = 3,
  parameter int NUM_SHOTS   = 1,
  parameter int NUM_FILTERS = 4,
  parameter int TIMEOUT_SEC = 30
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       frame_done_in,
  input  logic       process_done_in,
  input  logic       send_done_in,
  output logic [2:0] state_out,
  output logic       freeze_out,
  output logic [3:0] countdown_out,
  output logic [2:0] shot_idx_out,
  output logic [3:0] filter_sel_out,
  output logic       process_start_out,
  output logic       send_start_out,
  output logic       busy_out
);

  localparam logic [3:0] CNT_INIT  = 4'(COUNT_SEC);
  localparam logic [2:0] SHOT_LAST = 3'(NUM_SHOTS - 1);
  localparam logic [3:0] FILT_LAST = 4'(NUM_FILTERS - 1);

  pb_state_t  state_q, state_d;
  logic       freeze_q, freeze_d;
  logic [3:0] cd_q, cd_d;
  logic [2:0] shot_q, shot_d;
  logic [3:0] filt_q, filt_d;
  logic       pstart_q, pstart_d;
  logic       sstart_q, sstart_d;
  logic       busy_q;
  logic [2:0] btn, btn_q, edge_q;
  logic       start_e, left_e, right_e;
  logic       tick, restart;

`ifdef PHOTOBOOTH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_SEC - 1);
  logic [TW-1:0] to_q, to_d;
`endif

  assign btn = {start_in, left_in, right_in};
  assign {start_e, left_e, right_e} = edge_q;

  // button history and registered rising-edge strobes
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      btn_q  <= '0;
      edge_q <= '0;
    end else begin
      btn_q  <= btn;
      edge_q <= btn & ~btn_q;
    end
  end

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .restart_in(restart),
    .tick_out  (tick)
  );

  // next state, datapath updates and handshake strobes
  always_comb begin
    state_d  = state_q;
    freeze_d = freeze_q;
    cd_d     = cd_q;
    shot_d   = shot_q;
    filt_d   = filt_q;
    pstart_d = 1'b0;
    sstart_d = 1'b0;
    restart  = 1'b0;
`ifdef PHOTOBOOTH_TIMEOUT_EN
    to_d     = to_q;
`endif
    unique case (state_q)
      PB_IDLE: begin
        if (start_e) begin
          state_d = PB_COUNTDOWN;
          cd_d    = CNT_INIT;
          restart = 1'b1;
        end
      end
      PB_COUNTDOWN: begin
        if (tick) begin
          if (cd_q == 4'd1) begin
            state_d = PB_CAPTURE;
            cd_d    = '0;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end
      end
      PB_CAPTURE: begin
        if (frame_done_in) begin
          restart = 1'b1;
          if (shot_q < SHOT_LAST) begin
            shot_d  = shot_q + 3'd1;
            state_d = PB_COUNTDOWN;
            cd_d    = CNT_INIT;
          end else begin
            state_d  = PB_CHOOSE;
            freeze_d = 1'b1;
`ifdef PHOTOBOOTH_TIMEOUT_EN
            to_d     = '0;
`endif
          end
        end
      end
      PB_CHOOSE: begin
        if (start_e) begin
          pstart_d = 1'b1;
          state_d  = PB_PROCESS;
        end else if (left_e != right_e) begin
          restart = 1'b1;
`ifdef PHOTOBOOTH_TIMEOUT_EN
          to_d    = '0;
`endif
          if (left_e)
            filt_d = (filt_q == '0) ? FILT_LAST : filt_q - 4'd1;
          else
            filt_d = (filt_q == FILT_LAST) ? '0 : filt_q + 4'd1;
        end
`ifdef PHOTOBOOTH_TIMEOUT_EN
        else if (tick) begin
          if (to_q == TO_LAST) begin
            state_d  = PB_IDLE;
            freeze_d = 1'b0;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
`endif
      end
      PB_PROCESS: begin
        if (process_done_in) begin
          sstart_d = 1'b1;
          state_d  = PB_SEND;
        end
      end
      PB_SEND: begin
        if (send_done_in) begin
          freeze_d = 1'b0;
          state_d  = PB_IDLE;
        end
      end
      default: begin
        state_d  = PB_IDLE;
        freeze_d = 1'b0;
      end
    endcase
    if (state_d == PB_IDLE) begin
      shot_d = '0;
      filt_d = FILT_NONE;
      cd_d   = '0;
    end
  end

  // registered state and outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= PB_IDLE;
      freeze_q <= 1'b0;
      cd_q     <= '0;
      shot_q   <= '0;
      filt_q   <= FILT_NONE;
      pstart_q <= 1'b0;
      sstart_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      freeze_q <= freeze_d;
      cd_q     <= cd_d;
      shot_q   <= shot_d;
      filt_q   <= filt_d;
      pstart_q <= pstart_d;
      sstart_q <= sstart_d;
      busy_q   <= (state_d != PB_IDLE);
    end
  end

`ifdef PHOTOBOOTH_TIMEOUT_EN
  // CHOOSE idle-seconds counter
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) to_q <= '0;
    else           to_q <= to_d;
  end
`endif

  assign state_out         = state_q;
  assign freeze_out        = freeze_q;
  assign countdown_out     = cd_q;
  assign shot_idx_out      = shot_q;
  assign filter_sel_out    = filt_q;
  assign process_start_out = pstart_q;
  assign send_start_out    = sstart_q;
  assign busy_out          = busy_q;

endmodule

// File: tb/tb_photobooth_ctrl.sv
// tb_photobooth_ctrl: scoreboard bench for photobooth_ctrl with
// CLK_HZ=10, three shots and four filters.
module tb_photobooth_ctrl;
  import photobooth_pkg::*;

  localparam int CLK_HZ      = 10;
  localparam int COUNT_SEC   = 3;
  localparam int NUM_SHOTS   = 3;
  localparam int NUM_FILTERS = 4;
  localparam int TIMEOUT_SEC = 2;

  typedef struct packed {
    logic [2:0] st;
    logic       frz;
    logic [3:0] cd;
    logic [2:0] sh;
    logic [3:0] fs;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, left = 1'b0, right = 1'b0;
  logic fd = 1'b0, pd = 1'b0, sd = 1'b0;
  logic [2:0] state_o;
  logic       freeze_o;
  logic [3:0] cd_o;
  logic [2:0] sh_o;
  logic [3:0] fs_o;
  logic       ps_o, ss_o, busy_o;

  int checks = 0;
  int errors = 0;
  int ps_cnt = 0;
  int ss_cnt = 0;
  snap_t sb[$];

  always #5 clk = ~clk;

  photobooth_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .COUNT_SEC  (COUNT_SEC),
    .NUM_SHOTS  (NUM_SHOTS),
    .NUM_FILTERS(NUM_FILTERS),
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .start_in         (start),
    .left_in          (left),
    .right_in         (right),
    .frame_done_in    (fd),
    .process_done_in  (pd),
    .send_done_in     (sd),
    .state_out        (state_o),
    .freeze_out       (freeze_o),
    .countdown_out    (cd_o),
    .shot_idx_out     (sh_o),
    .filter_sel_out   (fs_o),
    .process_start_out(ps_o),
    .send_start_out   (ss_o),
    .busy_out         (busy_o)
  );

  always @(negedge clk) begin
    if (ps_o) ps_cnt++;
    if (ss_o) ss_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic snap_t mk(int st, int frz, int cd, int sh, int fs);
    snap_t s;
    s.st = 3'(st); s.frz = 1'(frz); s.cd = 4'(cd);
    s.sh = 3'(sh); s.fs = 4'(fs);
    return s;
  endfunction

  function automatic snap_t snap();
    return {state_o, freeze_o, cd_o, sh_o, fs_o};
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d frz=%0d cd=%0d sh=%0d fs=%0d",
                     s.st, s.frz, s.cd, s.sh, s.fs);
  endfunction

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(logic s, logic l, logic r);
    start = s; left = l; right = r;
    cyc(1);
    start = 1'b0; left = 1'b0; right = 1'b0;
    cyc(1);
  endtask

  // 0: frame_done, 1: process_done, 2: send_done
  task automatic pulse(int which);
    fd = (which == 0); pd = (which == 1); sd = (which == 2);
    cyc(1);
    fd = 1'b0; pd = 1'b0; sd = 1'b0;
  endtask

  task automatic test_reset();
    snap_t e, a;
    rst_n = 1'b0;
    cyc(2);
    sb.push_back(mk(0, 0, 0, 0, 0));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL reset: got %s want %s", fmt(a), fmt(e));
    end
    checks++;
    if ({busy_o, ps_o, ss_o} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {busy_o, ps_o, ss_o});
    end
    rst_n = 1'b1;
    cyc(3);
    sb.push_back(mk(0, 0, 0, 0, 0));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL post_reset: got %s want %s", fmt(a), fmt(e));
    end
  endtask

  task automatic run_session();
    snap_t e, a;
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL busy: got %b want 1", busy_o);
    end
    for (int s = 0; s < NUM_SHOTS; s++) begin
      for (int k = COUNT_SEC; k >= 1; k--) begin
        sb.push_back(mk(1, 0, k, s, 0));
        e = sb.pop_front(); a = snap(); checks++;
        if (a !== e) begin
          errors++; $display("FAIL countdown: got %s want %s", fmt(a), fmt(e));
        end
        cyc(CLK_HZ);
      end
      sb.push_back(mk(2, 0, 0, s, 0));
      e = sb.pop_front(); a = snap(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL capture: got %s want %s", fmt(a), fmt(e));
      end
      pulse(0);
    end
    sb.push_back(mk(3, 1, 0, NUM_SHOTS - 1, 0));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL freeze: got %s want %s", fmt(a), fmt(e));
    end
  endtask

  task automatic test_session();
    run_session();
  endtask

  task automatic test_filter();
    snap_t e, a;
    logic l_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic r_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   f_t [5] = '{0, 3, 0, 1, 1};
    pulse(0);
    pulse(1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) press(1'b0, l_t[i], r_t[i]);
      sb.push_back(mk(3, 1, 0, NUM_SHOTS - 1, f_t[i]));
      e = sb.pop_front(); a = snap(); checks++;
      if (a !== e) begin
        errors++; $display("FAIL filter_%0d: got %s want %s", i, fmt(a), fmt(e));
      end
    end
    right = 1'b1;
    cyc(50);
    right = 1'b0;
    cyc(2);
    sb.push_back(mk(3, 1, 0, NUM_SHOTS - 1, 2));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL filter_held: got %s want %s", fmt(a), fmt(e));
    end
  endtask

  task automatic test_handshake();
    snap_t e, a;
    int p0, s0;
    pulse(2);
    sb.push_back(mk(3, 1, 0, NUM_SHOTS - 1, 2));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL stray_send: got %s want %s", fmt(a), fmt(e));
    end
    p0 = ps_cnt; s0 = ss_cnt;
    press(1'b1, 1'b1, 1'b0);
    sb.push_back(mk(4, 1, 0, NUM_SHOTS - 1, 2));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL to_process: got %s want %s", fmt(a), fmt(e));
    end
    pulse(2);
    cyc(3);
    sb.push_back(mk(4, 1, 0, NUM_SHOTS - 1, 2));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL stray_in_proc: got %s want %s", fmt(a), fmt(e));
    end
    checks++;
    if (ps_cnt - p0 !== 1) begin
      errors++; $display("FAIL pstart_width: got %0d want 1", ps_cnt - p0);
    end
    pulse(1);
    sb.push_back(mk(5, 1, 0, NUM_SHOTS - 1, 2));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL to_send: got %s want %s", fmt(a), fmt(e));
    end
    cyc(3);
    checks++;
    if (ss_cnt - s0 !== 1) begin
      errors++; $display("FAIL sstart_width: got %0d want 1", ss_cnt - s0);
    end
    pulse(2);
    sb.push_back(mk(0, 0, 0, 0, 0));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL to_idle: got %s busy=%b want %s busy=0", fmt(a), busy_o, fmt(e));
    end
    checks++;
    if (ps_cnt - p0 !== 1) begin
      errors++; $display("FAIL pstart_total: got %0d want 1", ps_cnt - p0);
    end
  endtask

  task automatic test_reset_mid();
    snap_t e, a;
    cyc(2);
    run_session();
    press(1'b1, 1'b0, 1'b0);
    sb.push_back(mk(4, 1, 0, NUM_SHOTS - 1, 0));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL pre_reset: got %s want %s", fmt(a), fmt(e));
    end
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e || {busy_o, ps_o, ss_o} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got %s flags=%b want %s flags=000",
               fmt(a), {busy_o, ps_o, ss_o}, fmt(e));
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

`ifdef PHOTOBOOTH_TIMEOUT_EN
  task automatic test_timeout();
    snap_t e, a;
    int p0;
    run_session();
    p0 = ps_cnt;
    cyc(19);
    sb.push_back(mk(3, 1, 0, NUM_SHOTS - 1, 0));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL to_wait: got %s want %s", fmt(a), fmt(e));
    end
    cyc(1);
    sb.push_back(mk(0, 0, 0, 0, 0));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e || ps_cnt != p0) begin
      errors++; $display("FAIL to_expire: got %s want %s", fmt(a), fmt(e));
    end
    run_session();
    cyc(14);
    press(1'b0, 1'b0, 1'b1);
    cyc(19);
    sb.push_back(mk(3, 1, 0, NUM_SHOTS - 1, 1));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e) begin
      errors++; $display("FAIL to_extend: got %s want %s", fmt(a), fmt(e));
    end
    cyc(1);
    sb.push_back(mk(0, 0, 0, 0, 0));
    e = sb.pop_front(); a = snap(); checks++;
    if (a !== e || ps_cnt != p0) begin
      errors++; $display("FAIL to_expire2: got %s want %s", fmt(a), fmt(e));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_session();
    test_filter();
    test_handshake();
    test_reset_mid();
`ifdef PHOTOBOOTH_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
